// File: rtl/aes_in_sched.sv
// aes_in_sched: feeds the AES-256 core from the key and data input FIFOs.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   load_key                 one-cycle request to load a new key
//   key_empty/key_word/key_rd    key FIFO (first-word-fall-through) handshake
//   data_empty/data_word/data_rd data FIFO (first-word-fall-through) handshake
//   key_o, key_load_o        assembled 256-bit key and its one-cycle load pulse
//   blk_o, blk_valid, blk_ready  assembled 128-bit block with valid/ready
//   core_done                core finished the current block
//   key_loaded, busy, err    status: key present, not idle, sticky watchdog error
// Optional build macro CTRL_TIMEOUT_EN adds a watchdog over BLK_OUT/WAIT_DONE
// that drops the block and raises err after TIMEOUT_CYC cycles.
module aes_in_sched #(
    parameter int KEY_WORDS   = 8,
    parameter int BLK_WORDS   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_key,
    input  logic         key_empty,
    input  logic [31:0]  key_word,
    output logic         key_rd,
    input  logic         data_empty,
    input  logic [31:0]  data_word,
    output logic         data_rd,
    output logic [255:0] key_o,
    output logic         key_load_o,
    output logic [127:0] blk_o,
    output logic         blk_valid,
    input  logic         blk_ready,
    input  logic         core_done,
    output logic         key_loaded,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, LOAD_KEY, KEY_OUT, LOAD_DATA, BLK_OUT, WAIT_DONE} state_t;
    localparam logic [2:0] KEY_LAST = 3'(KEY_WORDS - 1);
    localparam logic [2:0] BLK_LAST = 3'(BLK_WORDS - 1);
    state_t     state, state_nx;
    logic [2:0] wcnt;
    logic       key_pend, key_last, blk_last, tmo;
    assign key_rd   = (state == LOAD_KEY) & !key_empty;
    assign data_rd  = (state == LOAD_DATA) & !data_empty;
    assign key_last = key_rd & (wcnt == KEY_LAST);
    assign blk_last = data_rd & (wcnt == BLK_LAST);
`ifdef CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr;
    assign tmo = (state == BLK_OUT || state == WAIT_DONE) && tmr == TW'(TIMEOUT_CYC - 1);
    // restarts on every state change so each waiting state gets a full budget
    always_ff @(posedge clk) begin
        if (!resetn || state_nx != state)
            tmr <= '0;
        else if (state == BLK_OUT || state == WAIT_DONE)
            tmr <= tmr + 1'b1;
    end
    always_ff @(posedge clk)
        err <= resetn & (err | tmo);
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:      state_nx = (key_pend & !key_empty) ? LOAD_KEY :
                                  (key_loaded & !data_empty) ? LOAD_DATA : IDLE;
            LOAD_KEY:  state_nx = key_last ? KEY_OUT : LOAD_KEY;
            KEY_OUT:   state_nx = IDLE;
            LOAD_DATA: state_nx = blk_last ? BLK_OUT : LOAD_DATA;
            BLK_OUT:   state_nx = tmo ? IDLE : blk_ready ? WAIT_DONE : BLK_OUT;
            WAIT_DONE: state_nx = (tmo | core_done) ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end
    // word i lands at the MSB end: lsb offset of word i is 32*(last-i) = {~i, 5'b0}
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            wcnt       <= '0;
            key_pend   <= 1'b0;
            key_o      <= '0;
            blk_o      <= '0;
            key_load_o <= 1'b0;
            key_loaded <= 1'b0;
            blk_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            key_pend   <= (key_pend | load_key) & !key_last;
            wcnt       <= (key_last | blk_last) ? 3'd0 : (key_rd | data_rd) ? wcnt + 3'd1 : wcnt;
            if (key_rd)
                key_o[{~wcnt, 5'b0} +: 32] <= key_word;
            if (data_rd)
                blk_o[{~wcnt[1:0], 5'b0} +: 32] <= data_word;
            key_load_o <= key_last;
            key_loaded <= key_loaded | key_last;
            blk_valid  <= state_nx == BLK_OUT;
            busy       <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_aes_in_sched.sv
// tb_aes_in_sched: directed self-checking bench for aes_in_sched
module tb_aes_in_sched;
  logic         clk = 1'b0;
  logic         resetn, load_key, key_empty, key_rd, data_empty, data_rd;
  logic [31:0]  key_word, data_word;
  logic [255:0] key_o;
  logic [127:0] blk_o;
  logic         key_load_o, blk_valid, blk_ready, core_done, key_loaded, busy, err;
  logic [31:0]  kq[$], dq[$];
  int           n_vec = 0, n_mis = 0;
  int           n_krd, n_drd, n_kl, n_bv;
  int           t_kl, t_bv, t_kr0, t_kr1;
  logic [255:0] key_s;
  logic [127:0] blk_s;
  logic         kld_s;
  always #5 clk = ~clk;
  aes_in_sched dut (
    .clk(clk), .resetn(resetn), .load_key(load_key),
    .key_empty(key_empty), .key_word(key_word), .key_rd(key_rd),
    .data_empty(data_empty), .data_word(data_word), .data_rd(data_rd),
    .key_o(key_o), .key_load_o(key_load_o), .blk_o(blk_o),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .core_done(core_done),
    .key_loaded(key_loaded), .busy(busy), .err(err)
  );
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic upd();
    key_empty  = kq.size() == 0;
    key_word   = key_empty ? 32'd0 : kq[0];
    data_empty = dq.size() == 0;
    data_word  = data_empty ? 32'd0 : dq[0];
  endtask
  task automatic cyc();
    logic kr, dr;
    #1;
    kr = key_rd;
    dr = data_rd;
    n_krd += int'(kr);
    n_drd += int'(dr);
    n_kl  += int'(key_load_o);
    n_bv  += int'(blk_valid);
    @(posedge clk);
    #1;
    if (kr) void'(kq.pop_front());
    if (dr) void'(dq.pop_front());
    upd();
    @(negedge clk);
  endtask
  initial begin
    resetn = 1'b0; load_key = 1'b0; blk_ready = 1'b0; core_done = 1'b0;
    upd();
    @(negedge clk);
    cyc(); cyc();
    resetn = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {key_load_o, blk_valid, key_loaded, err, key_rd, data_rd}, 6'd0);
    chk("rst_key_o", key_o, 256'd0);
    chk("rst_blk_o", blk_o, 128'd0);
    for (int i = 0; i < 8; i++) kq.push_back(32'(i + 1));
    for (int i = 0; i < 4; i++) dq.push_back(32'hAAAA0000 + 32'(i));
    upd();
    n_drd = 0;
    repeat (5) cyc();
    chk("no_data_before_key", n_drd, 0);
    chk("idle_not_busy", busy, 1'b0);
    blk_ready = 1'b1;
    n_krd = 0; n_drd = 0; n_kl = 0; n_bv = 0;
    t_kl = -1; t_bv = -1; t_kr0 = -1; t_kr1 = -1;
    kld_s = 1'b0; key_s = '0; blk_s = '0;
    load_key = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (key_load_o && t_kl < 0) t_kl = i;
      if (blk_valid && t_bv < 0) t_bv = i;
      if (key_rd) begin
        if (t_kr0 < 0) t_kr0 = i;
        t_kr1 = i;
      end
      if (i == 11) begin
        key_s = key_o;
        kld_s = key_loaded;
      end
      if (i == 16) blk_s = blk_o;
      cyc();
      load_key = 1'b0;
    end
    chk("key_latency", t_kl, 10);
    chk("key_load_pulses", n_kl, 1);
    chk("key_rd_count", n_krd, 8);
    chk("key_rd_first", t_kr0, 2);
    chk("key_rd_last", t_kr1, 9);
    chk("key_value", key_s, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    chk("key_loaded", kld_s, 1'b1);
    chk("data_latency", t_bv, 16);
    chk("blk_valid_pulses", n_bv, 1);
    chk("data_rd_count", n_drd, 4);
    chk("blk_value", blk_s, 128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003);
    chk("busy_wait_done", busy, 1'b1);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    chk("idle_after_done", busy, 1'b0);
    blk_ready = 1'b0;
    dq.push_back(32'h12340000);
    dq.push_back(32'h12340001);
    upd();
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      chk("stall_no_rd", data_rd, 1'b0);
      chk("stall_busy", busy, 1'b1);
      cyc();
    end
    dq.push_back(32'h12340002);
    dq.push_back(32'h12340003);
    upd();
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", blk_valid, 1'b1);
      chk("bp_blk", blk_o, 128'h12340000_12340001_12340002_12340003);
      cyc();
    end
    blk_ready = 1'b1;
    cyc();
    chk("bp_valid_drop", blk_valid, 1'b0);
    chk("bp_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) kq.push_back(32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 4; i++) dq.push_back(32'h22220000 + 32'(i));
    upd();
    load_key = 1'b1;
    cyc();
    load_key = 1'b0;
    chk("no_preempt_krd", key_rd, 1'b0);
    chk("no_preempt_drd", data_rd, 1'b0);
    n_drd = 0;
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    for (int i = 0; i < 20 && !key_load_o; i++) cyc();
    chk("prio_key_load", key_load_o, 1'b1);
    chk("prio_no_drd", n_drd, 0);
    chk("prio_key", key_o, 256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007);
    repeat (4) cyc();
    chk("pre_rst_drd", data_rd, 1'b1);
    resetn = 1'b0;
    cyc();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", blk_valid, 1'b0);
    chk("mid_rst_rd", {key_rd, data_rd}, 2'b00);
    chk("mid_rst_kld", key_loaded, 1'b0);
    chk("mid_rst_key", key_o, 256'd0);
    chk("mid_rst_blk", blk_o, 128'd0);
    resetn = 1'b1;
    cyc(); cyc();
    chk("post_rst_no_drd", data_rd, 1'b0);
    chk("post_rst_idle", busy, 1'b0);
    dq.delete();
    upd();
    for (int i = 0; i < 8; i++) kq.push_back(32'(i));
    for (int i = 0; i < 4; i++) dq.push_back(32'h33330000 + 32'(i));
    upd();
    load_key = 1'b1;
    cyc();
    load_key = 1'b0;
    for (int i = 0; i < 40 && !blk_valid; i++) cyc();
    chk("to_blk_valid", blk_valid, 1'b1);
    chk("to_blk", blk_o, 128'h33330000_33330001_33330002_33330003);
    cyc();
    repeat (63) cyc();
    chk("to_busy_63", busy, 1'b1);
    chk("to_err_63", err, 1'b0);
    cyc();
`ifdef CTRL_TIMEOUT_EN
    chk("to_busy_64", busy, 1'b0);
    chk("to_err_64", err, 1'b1);
    repeat (10) cyc();
    chk("to_err_sticky", err, 1'b1);
    chk("to_idle", busy, 1'b0);
`else
    chk("to_busy_64", busy, 1'b1);
    chk("to_err_64", err, 1'b0);
    repeat (10) cyc();
    chk("to_still_wait", busy, 1'b1);
    chk("to_err_zero", err, 1'b0);
`endif
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    chk("final_idle", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
